// File: rtl/target_addr_table_if.sv
// Interface for target_addr_table: CSR staging inputs, bus-event inputs, lookup
// request/response and the effective table outputs.
// master: target FSM / CSR block side (drives requests). slave: the address table.
interface target_addr_table_if #(
  parameter int NUM_TARGETS = 2,
  parameter int IDX_W       = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
);
  // software-facing CSR image, target i at [7i+:7]
  logic [7*NUM_TARGETS-1:0] csr_sta_addr;
  logic [NUM_TARGETS-1:0]   csr_sta_valid;
  logic [7*NUM_TARGETS-1:0] csr_dyn_addr;
  logic [NUM_TARGETS-1:0]   csr_dyn_valid;
  logic                     csr_wr;
  logic                     bus_idle;
  // bus events from the target FSM
  logic                     daa_set;
  logic [IDX_W-1:0]         daa_idx;
  logic [6:0]               daa_addr;
  logic                     rstdaa;
  // address lookup
  logic                     lkp_valid;
  logic [6:0]               lkp_addr;
  logic                     lkp_hit;
  logic [IDX_W-1:0]         lkp_idx;
  logic                     lkp_hj;
  logic                     lkp_bcast;
  // effective table
  logic [7*NUM_TARGETS-1:0] sta_addr;
  logic [NUM_TARGETS-1:0]   sta_valid;
  logic [7*NUM_TARGETS-1:0] dyn_addr;
  logic [NUM_TARGETS-1:0]   dyn_valid;
  logic [7*NUM_TARGETS-1:0] ibi_addr;
  logic [NUM_TARGETS-1:0]   ibi_valid;
  logic                     pending;
  logic                     conflict;
  logic                     wb_req;
  logic [IDX_W-1:0]         wb_idx;

  modport master (
    output csr_sta_addr, csr_sta_valid, csr_dyn_addr, csr_dyn_valid, csr_wr, bus_idle,
    output daa_set, daa_idx, daa_addr, rstdaa, lkp_valid, lkp_addr,
    input  lkp_hit, lkp_idx, lkp_hj, lkp_bcast,
    input  sta_addr, sta_valid, dyn_addr, dyn_valid, ibi_addr, ibi_valid,
    input  pending, conflict, wb_req, wb_idx
  );

  modport slave (
    input  csr_sta_addr, csr_sta_valid, csr_dyn_addr, csr_dyn_valid, csr_wr, bus_idle,
    input  daa_set, daa_idx, daa_addr, rstdaa, lkp_valid, lkp_addr,
    output lkp_hit, lkp_idx, lkp_hj, lkp_bcast,
    output sta_addr, sta_valid, dyn_addr, dyn_valid, ibi_addr, ibi_valid,
    output pending, conflict, wb_req, wb_idx
  );
endinterface

// File: rtl/target_addr_table.sv
// Registered table of NUM_TARGETS target identities (static/dynamic address + valid).
// Latency: lookup 1 cycle; CSR write committed the edge after pending is set, if bus idle.
// Backpressure: none; CSR writes wait in 'pending' while the bus is busy or a bus event fires.
// Ports: clk_i, rst_ni (async active-low), bus (target_addr_table_if.slave).
module target_addr_table #(
  parameter int         NUM_TARGETS = 2,
  parameter logic [6:0] HJ_ADDR     = 7'h02,
  localparam int        IDX_W       = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  target_addr_table_if.slave   bus
);

  localparam logic [6:0]     BCAST_ADDR = 7'h7E;
  localparam logic [IDX_W:0] NUM_T      = NUM_TARGETS[IDX_W:0];

  logic [NUM_TARGETS-1:0][6:0] sta_addr_q, dyn_addr_q;
  logic [NUM_TARGETS-1:0]      sta_valid_q, dyn_valid_q;
  logic                        pending_q;
  logic                        conflict_q, conflict_d;
  logic                        wb_req_q;
  logic [IDX_W-1:0]            wb_idx_q;
  logic                        lkp_hit_q, lkp_hj_q, lkp_bcast_q;
  logic [IDX_W-1:0]            lkp_idx_q;
  logic                        lkp_hit_d, lkp_hj_d, lkp_bcast_d, lkp_found;
  logic [IDX_W-1:0]            lkp_idx_d;

  logic bus_evt, commit, daa_ok;

  // Any bus event, even a rejected DAA, holds off the commit for that cycle.
  assign bus_evt = bus.daa_set | bus.rstdaa;
  assign commit  = pending_q & bus.bus_idle & ~bus_evt;
  assign daa_ok  = bus.daa_set && ({1'b0, bus.daa_idx} < NUM_T) &&
                   (bus.daa_addr != HJ_ADDR) && (bus.daa_addr != BCAST_ADDR);

  // Table: RSTDAA > DAA assignment > CSR commit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sta_addr_q  <= '0;
      sta_valid_q <= '0;
      dyn_addr_q  <= '0;
      dyn_valid_q <= '0;
    end else if (bus.rstdaa) begin
      dyn_valid_q <= '0;
    end else if (daa_ok) begin
      dyn_addr_q[bus.daa_idx]  <= bus.daa_addr;
      dyn_valid_q[bus.daa_idx] <= 1'b1;
    end else if (commit) begin
      sta_addr_q  <= bus.csr_sta_addr;
      sta_valid_q <= bus.csr_sta_valid;
      dyn_addr_q  <= bus.csr_dyn_addr;
      dyn_valid_q <= bus.csr_dyn_valid;
    end
  end

  // A write landing on the commit edge keeps pending set so the newer value follows.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= 1'b0;
      wb_req_q  <= 1'b0;
      wb_idx_q  <= '0;
    end else begin
      pending_q <= bus.csr_wr | (pending_q & ~commit);
      wb_req_q  <= bus.rstdaa | daa_ok;
      if (bus.rstdaa) begin
        wb_idx_q <= '0;
      end else if (daa_ok) begin
        wb_idx_q <= bus.daa_idx;
      end
    end
  end

  // Lookup against the current (pre-update) table. Dynamic matches are
  // searched over all targets before any static match is considered.
  always_comb begin
    lkp_hit_d   = 1'b0;
    lkp_hj_d    = 1'b0;
    lkp_bcast_d = 1'b0;
    lkp_idx_d   = '0;
    lkp_found   = 1'b0;
    if (bus.lkp_valid) begin
      lkp_bcast_d = (bus.lkp_addr == BCAST_ADDR);
      if (bus.lkp_addr == HJ_ADDR) begin
        lkp_hit_d = 1'b1;
        lkp_hj_d  = 1'b1;
      end else begin
        for (int i = 0; i < NUM_TARGETS; i++) begin
          if (!lkp_found && dyn_valid_q[i] && (dyn_addr_q[i] == bus.lkp_addr)) begin
            lkp_found = 1'b1;
            lkp_idx_d = IDX_W'(i);
          end
        end
        for (int i = 0; i < NUM_TARGETS; i++) begin
          if (!lkp_found && sta_valid_q[i] && (sta_addr_q[i] == bus.lkp_addr)) begin
            lkp_found = 1'b1;
            lkp_idx_d = IDX_W'(i);
          end
        end
        lkp_hit_d = lkp_found;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lkp_hit_q   <= 1'b0;
      lkp_idx_q   <= '0;
      lkp_hj_q    <= 1'b0;
      lkp_bcast_q <= 1'b0;
    end else begin
      lkp_hit_q   <= lkp_hit_d;
      lkp_idx_q   <= lkp_idx_d;
      lkp_hj_q    <= lkp_hj_d;
      lkp_bcast_q <= lkp_bcast_d;
    end
  end

  // Conflict: slots 0..N-1 are static addresses, N..2N-1 dynamic. Slot a and
  // a+N belong to the same target and may legitimately share an address.
  always_comb begin
    conflict_d = 1'b0;
    for (int a = 0; a < 2*NUM_TARGETS; a++) begin
      logic [6:0] addr_a;
      logic       vld_a;
      addr_a = (a < NUM_TARGETS) ? sta_addr_q[a % NUM_TARGETS]  : dyn_addr_q[a % NUM_TARGETS];
      vld_a  = (a < NUM_TARGETS) ? sta_valid_q[a % NUM_TARGETS] : dyn_valid_q[a % NUM_TARGETS];
      if (vld_a && ((addr_a == HJ_ADDR) || (addr_a == BCAST_ADDR))) begin
        conflict_d = 1'b1;
      end
      for (int b = a + 1; b < 2*NUM_TARGETS; b++) begin
        logic [6:0] addr_b;
        logic       vld_b;
        addr_b = (b < NUM_TARGETS) ? sta_addr_q[b % NUM_TARGETS]  : dyn_addr_q[b % NUM_TARGETS];
        vld_b  = (b < NUM_TARGETS) ? sta_valid_q[b % NUM_TARGETS] : dyn_valid_q[b % NUM_TARGETS];
        if (vld_a && vld_b && (addr_a == addr_b) && (b != a + NUM_TARGETS)) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  // IBI identity: dynamic address once assigned, otherwise the static one.
  for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_ibi
    assign bus.ibi_addr[7*g +: 7] = dyn_valid_q[g] ? dyn_addr_q[g] : sta_addr_q[g];
  end

  assign bus.ibi_valid = sta_valid_q | dyn_valid_q;
  assign bus.sta_addr  = sta_addr_q;
  assign bus.sta_valid = sta_valid_q;
  assign bus.dyn_addr  = dyn_addr_q;
  assign bus.dyn_valid = dyn_valid_q;
  assign bus.pending   = pending_q;
  assign bus.conflict  = conflict_q;
  assign bus.wb_req    = wb_req_q;
  assign bus.wb_idx    = wb_idx_q;
  assign bus.lkp_hit   = lkp_hit_q;
  assign bus.lkp_idx   = lkp_idx_q;
  assign bus.lkp_hj    = lkp_hj_q;
  assign bus.lkp_bcast = lkp_bcast_q;

endmodule

// File: tb/tb_target_addr_table.sv
// Directed bench for target_addr_table with three targets (so an out-of-range
// index is representable). Lookup expectations go through a scoreboard queue.
module tb_target_addr_table;
  localparam int N  = 3;
  localparam int IW = 2;

  typedef struct packed {
    logic          hit;
    logic [IW-1:0] idx;
    logic          hj;
    logic          bcast;
  } lkp_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  lkp_t exp_q[$];

  target_addr_table_if #(.NUM_TARGETS(N)) bus ();

  target_addr_table #(.NUM_TARGETS(N), .HJ_ADDR(7'h02)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic lookup(input logic [6:0] addr, input lkp_t e);
    lkp_t ex, obs;
    bus.lkp_valid = 1'b1;
    bus.lkp_addr  = addr;
    exp_q.push_back(e);
    tick();
    bus.lkp_valid = 1'b0;
    ex  = exp_q.pop_front();
    obs = {bus.lkp_hit, bus.lkp_idx, bus.lkp_hj, bus.lkp_bcast};
    check($sformatf("lkp_%02h{hit,idx,hj,bc}", addr), 32'(obs), 32'(ex));
  endtask

  task automatic daa(input logic [IW-1:0] idx, input logic [6:0] addr);
    bus.daa_set  = 1'b1;
    bus.daa_idx  = idx;
    bus.daa_addr = addr;
    tick();
    bus.daa_set  = 1'b0;
  endtask

  initial begin
    bus.csr_sta_addr  = '0;
    bus.csr_sta_valid = '0;
    bus.csr_dyn_addr  = '0;
    bus.csr_dyn_valid = '0;
    bus.csr_wr        = 1'b0;
    bus.bus_idle      = 1'b0;
    bus.daa_set       = 1'b0;
    bus.daa_idx       = '0;
    bus.daa_addr      = '0;
    bus.rstdaa        = 1'b0;
    bus.lkp_valid     = 1'b0;
    bus.lkp_addr      = '0;

    // Reset
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();
    check("rst_sta_valid", 32'(bus.sta_valid), 32'h0);
    check("rst_dyn_valid", 32'(bus.dyn_valid), 32'h0);
    check("rst_pending",   32'(bus.pending),   32'h0);
    check("rst_conflict",  32'(bus.conflict),  32'h0);
    check("rst_wb_req",    32'(bus.wb_req),    32'h0);
    check("rst_lkp", 32'({bus.lkp_hit, bus.lkp_idx, bus.lkp_hj, bus.lkp_bcast}), 32'h0);

    // CSR write on an idle bus: pending for one cycle, then committed
    bus.csr_sta_addr  = {7'h00, 7'h00, 7'h5A};
    bus.csr_sta_valid = 3'b001;
    bus.bus_idle      = 1'b1;
    bus.csr_wr        = 1'b1;
    tick();
    bus.csr_wr = 1'b0;
    check("t1_pending_set",    32'(bus.pending),   32'h1);
    check("t1_not_yet_valid",  32'(bus.sta_valid), 32'h0);
    tick();
    check("t1_sta_addr",       32'(bus.sta_addr),  32'(21'h5A));
    check("t1_sta_valid",      32'(bus.sta_valid), 32'h1);
    check("t1_pending_clr",    32'(bus.pending),   32'h0);

    // CSR write while bus busy: held for 20 cycles, commits once idle
    bus.csr_sta_addr  = {7'h00, 7'h44, 7'h5A};
    bus.csr_sta_valid = 3'b011;
    bus.bus_idle      = 1'b0;
    bus.csr_wr        = 1'b1;
    tick();
    bus.csr_wr = 1'b0;
    for (int c = 0; c < 20; c++) begin
      check("t2_hold_valid",   32'(bus.sta_valid), 32'h1);
      check("t2_hold_pending", 32'(bus.pending),   32'h1);
      tick();
    end
    bus.bus_idle = 1'b1;
    tick();
    check("t2_sta_addr",    32'(bus.sta_addr),  32'({7'h00, 7'h44, 7'h5A}));
    check("t2_sta_valid",   32'(bus.sta_valid), 32'h3);
    check("t2_pending_clr", 32'(bus.pending),   32'h0);

    // Dynamic address assignment to target 1
    daa(2'd1, 7'h31);
    check("t3_dyn_valid", 32'(bus.dyn_valid),       32'h2);
    check("t3_dyn_addr1", 32'(bus.dyn_addr[13:7]),  32'h31);
    check("t3_wb_req",    32'(bus.wb_req),          32'h1);
    check("t3_wb_idx",    32'(bus.wb_idx),          32'h1);
    check("t3_ibi_addr",  32'(bus.ibi_addr),        32'({7'h00, 7'h31, 7'h5A}));
    check("t3_ibi_valid", 32'(bus.ibi_valid),       32'h3);
    lookup(7'h31, '{hit: 1'b1, idx: 2'd1, hj: 1'b0, bcast: 1'b0});
    check("t3_wb_pulse_end", 32'(bus.wb_req), 32'h0);
    lookup(7'h44, '{hit: 1'b1, idx: 2'd1, hj: 1'b0, bcast: 1'b0});
    lookup(7'h5A, '{hit: 1'b1, idx: 2'd0, hj: 1'b0, bcast: 1'b0});
    lookup(7'h55, '{hit: 1'b0, idx: 2'd0, hj: 1'b0, bcast: 1'b0});
    check("t3_no_conflict", 32'(bus.conflict), 32'h0);

    // Dynamic 5A on target 2 collides with static 5A on target 0; dynamic wins the lookup
    daa(2'd2, 7'h5A);
    check("t3b_wb_idx", 32'(bus.wb_idx), 32'h2);
    tick();
    check("t3b_conflict", 32'(bus.conflict), 32'h1);
    lookup(7'h5A, '{hit: 1'b1, idx: 2'd2, hj: 1'b0, bcast: 1'b0});

    // RSTDAA + DAA + pending commit in one cycle
    bus.csr_sta_addr  = {7'h00, 7'h20, 7'h20};
    bus.csr_sta_valid = 3'b011;
    bus.csr_dyn_addr  = '0;
    bus.csr_dyn_valid = '0;
    bus.bus_idle      = 1'b0;
    bus.csr_wr        = 1'b1;
    tick();
    bus.csr_wr = 1'b0;
    check("t4_pending", 32'(bus.pending), 32'h1);
    bus.bus_idle = 1'b1;
    bus.rstdaa   = 1'b1;
    bus.daa_set  = 1'b1;
    bus.daa_idx  = 2'd0;
    bus.daa_addr = 7'h15;
    tick();
    bus.rstdaa  = 1'b0;
    bus.daa_set = 1'b0;
    check("t4_dyn_valid_clr", 32'(bus.dyn_valid),      32'h0);
    check("t4_dyn_addr_kept", 32'(bus.dyn_addr[13:7]), 32'h31);
    check("t4_daa_lost",      32'(bus.dyn_addr[6:0]),  32'h0);
    check("t4_commit_defer",  32'(bus.sta_addr),       32'({7'h00, 7'h44, 7'h5A}));
    check("t4_still_pending", 32'(bus.pending),        32'h1);
    check("t4_wb_req",        32'(bus.wb_req),         32'h1);
    check("t4_wb_idx",        32'(bus.wb_idx),         32'h0);
    tick();
    check("t4_committed",     32'(bus.sta_addr),       32'({7'h00, 7'h20, 7'h20}));
    check("t4_pending_clr",   32'(bus.pending),        32'h0);
    check("t4_wb_req_clr",    32'(bus.wb_req),         32'h0);
    check("t4_conflict_lag",  32'(bus.conflict),       32'h0);

    // Duplicate static addresses, HJ and broadcast lookups
    tick();
    check("t5_conflict", 32'(bus.conflict), 32'h1);
    lookup(7'h20, '{hit: 1'b1, idx: 2'd0, hj: 1'b0, bcast: 1'b0});
    lookup(7'h02, '{hit: 1'b1, idx: 2'd0, hj: 1'b1, bcast: 1'b0});
    lookup(7'h7E, '{hit: 1'b0, idx: 2'd0, hj: 1'b0, bcast: 1'b1});
    tick();
    check("t5_idle_lkp", 32'({bus.lkp_hit, bus.lkp_idx, bus.lkp_hj, bus.lkp_bcast}), 32'h0);

    // Rejected assignments, then one accepted
    daa(2'd0, 7'h02);
    check("t6_hj_dyn_valid", 32'(bus.dyn_valid), 32'h0);
    check("t6_hj_wb_req",    32'(bus.wb_req),    32'h0);
    daa(2'd3, 7'h33);
    check("t6_idx_dyn_valid", 32'(bus.dyn_valid), 32'h0);
    check("t6_idx_wb_req",    32'(bus.wb_req),    32'h0);
    daa(2'd0, 7'h7E);
    check("t6_bc_dyn_valid", 32'(bus.dyn_valid), 32'h0);
    check("t6_bc_wb_req",    32'(bus.wb_req),    32'h0);
    daa(2'd2, 7'h33);
    check("t6_ok_dyn_valid", 32'(bus.dyn_valid),       32'h4);
    check("t6_ok_dyn_addr2", 32'(bus.dyn_addr[20:14]), 32'h33);
    check("t6_ok_wb_req",    32'(bus.wb_req),          32'h1);
    check("t6_ok_wb_idx",    32'(bus.wb_idx),          32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
